// File: rtl/apple_spawner.sv
// apple_spawner: places a grid-aligned apple for the snake game.
// A free-running 16-bit LFSR supplies candidate cells. Out-of-range
// candidates are skipped. In-range ones are checked against snake occupancy
// over a req/ack handshake, and the apple respawns after it is eaten.
//
// Ports:
//   VGA_clk, reset          - single clock, synchronous active-high reset
//   xCount, yCount          - current pixel coordinates
//   eaten                   - snake head is on the apple cell
//   occ_req, occ_cell_x/y   - occupancy query (held stable until occ_ack)
//   occ_ack, occ_hit        - query answer; occ_hit is valid with occ_ack
//   apple                   - registered: the current pixel is inside the apple
//   apple_x, apple_y        - apple pixel origin
//   apple_valid, board_full - an apple is placed / placement abandoned
//   apples_eaten            - saturating eaten counter
module apple_spawner #(
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter int          CELL      = 10,
  parameter int          X_W       = 10,
  parameter int          Y_W       = 9,
  parameter int          CX_W      = 6,
  parameter int          CY_W      = 6,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 255,
  parameter int          CNT_W     = 8
) (
  input  logic             VGA_clk,
  input  logic             reset,
  input  logic [X_W-1:0]   xCount,
  input  logic [Y_W-1:0]   yCount,
  input  logic             eaten,
  output logic             occ_req,
  output logic [CX_W-1:0]  occ_cell_x,
  output logic [CY_W-1:0]  occ_cell_y,
  input  logic             occ_ack,
  input  logic             occ_hit,
  output logic             apple,
  output logic [X_W-1:0]   apple_x,
  output logic [Y_W-1:0]   apple_y,
  output logic             apple_valid,
  output logic             board_full,
  output logic [CNT_W-1:0] apples_eaten
);

  typedef enum logic [1:0] {PICK, QUERY, PLACED, FULL} state_t;

  localparam int            TRY_W     = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [15:0]   LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CX_W:0] CELLS_X   = (CX_W + 1)'(H_RES / CELL);
  localparam logic [CY_W:0] CELLS_Y   = (CY_W + 1)'(V_RES / CELL);
  localparam logic [X_W:0]  CELL_XW   = (X_W + 1)'(CELL);
  localparam logic [Y_W:0]  CELL_YW   = (Y_W + 1)'(CELL);

  state_t            state, state_d;
  logic [15:0]       lfsr;
  logic              lfsr_fb;
  logic [CX_W-1:0]   cand_x;
  logic [CY_W-1:0]   cand_y;
  logic              cand_ok;
  logic [TRY_W-1:0]  try_cnt, try_d, try_inc;
  logic [CX_W-1:0]   cell_x_d;
  logic [CY_W-1:0]   cell_y_d;
  logic [X_W-1:0]    apple_x_d;
  logic [Y_W-1:0]    apple_y_d;
  logic [CNT_W-1:0]  eaten_d;
  logic              pix_hit;

  // x^16+x^15+x^13+x^4+1, shifting toward the MSB
  assign lfsr_fb = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];
  assign cand_x  = lfsr[CX_W-1:0];
  assign cand_y  = lfsr[CX_W+CY_W-1:CX_W];
  assign cand_ok = ({1'b0, cand_x} < CELLS_X) && ({1'b0, cand_y} < CELLS_Y);
  assign try_inc = try_cnt + TRY_W'(1);

  assign occ_req     = (state == QUERY);
  assign apple_valid = (state == PLACED);
  assign board_full  = (state == FULL);

  // High bounds are computed one bit wider so a cell on the right/bottom
  // edge does not wrap.
  assign pix_hit = apple_valid
                && (xCount >= apple_x)
                && ({1'b0, xCount} < ({1'b0, apple_x} + CELL_XW))
                && (yCount >= apple_y)
                && ({1'b0, yCount} < ({1'b0, apple_y} + CELL_YW));

  always_comb begin
    state_d   = state;
    try_d     = try_cnt;
    cell_x_d  = occ_cell_x;
    cell_y_d  = occ_cell_y;
    apple_x_d = apple_x;
    apple_y_d = apple_y;
    eaten_d   = apples_eaten;
    case (state)
      PICK: begin
        if (cand_ok) begin
          cell_x_d = cand_x;
          cell_y_d = cand_y;
          state_d  = QUERY;
        end
      end
      QUERY: begin
        if (occ_ack) begin
          if (!occ_hit) begin
            state_d   = PLACED;
            apple_x_d = X_W'(32'(occ_cell_x) * CELL);
            apple_y_d = Y_W'(32'(occ_cell_y) * CELL);
            try_d     = '0;
          end else begin
            try_d   = try_inc;
            state_d = (try_inc == TRY_W'(MAX_TRIES)) ? FULL : PICK;
          end
        end
      end
      PLACED: begin
        if (eaten) begin
          state_d = PICK;
          if (apples_eaten != '1) eaten_d = apples_eaten + CNT_W'(1);
        end
      end
      FULL: ;
      default: state_d = PICK;
    endcase
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state        <= PICK;
      lfsr         <= LFSR_INIT;
      try_cnt      <= '0;
      occ_cell_x   <= '0;
      occ_cell_y   <= '0;
      apple_x      <= '0;
      apple_y      <= '0;
      apples_eaten <= '0;
      apple        <= 1'b0;
    end else begin
      state        <= state_d;
      lfsr         <= {lfsr[14:0], lfsr_fb};
      try_cnt      <= try_d;
      occ_cell_x   <= cell_x_d;
      occ_cell_y   <= cell_y_d;
      apple_x      <= apple_x_d;
      apple_y      <= apple_y_d;
      apples_eaten <= eaten_d;
      apple        <= pix_hit;
    end
  end

endmodule
